trap_ctrl: RTL and testbench

Trap sequencer for the machine-mode CSR file. Arbitrates synchronous exceptions, external/timer interrupts and `mret` from the pipeline, stalls and drains the pipeline, then performs the required CSR updates (`mepc`, `mcause`, `mstatus`) through the CSR file's single write port, one write per cycle. It finishes by issuing a PC redirect to the trap handler or the return address. It sits between the pipeline control unit and the CSR register file.

---
 rtl/trap_pkg.sv | 32 +++
 rtl/trap_prio.sv | 44 ++++
 rtl/trap_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg: shared constants and types for the machine-mode trap sequencer.
package trap_pkg;

  // CSR addresses touched or referenced by the trap sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Interrupt cause codes (low bits of mcause; the interrupt flag is the MSB)
  localparam logic [3:0] IRQ_EXT_CODE   = 4'd11;
  localparam logic [3:0] IRQ_TIMER_CODE = 4'd7;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Write mode for the CSR file port: plain write
  localparam logic [1:0] CSR_WMODE_WRITE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_W_EPC    = 3'd2,
    ST_W_CAUSE  = 3'd3,
    ST_W_STATUS = 3'd4,
    ST_REDIRECT = 3'd5
  } trap_state_e;

endpackage

// File: rtl/trap_prio.sv
// trap_prio: combinational priority encoder for trap/mret requests.
// Order: exception, external irq, timer irq, mret. Interrupts are gated by MIE.
module trap_prio #(
  parameter int XLEN = 32
) (
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            mret_req,
  input  logic            mie,
  output logic            take,
  output logic            is_mret,
  output logic            is_irq,
  output logic [XLEN-1:0] cause
);
  import trap_pkg::*;

  // Select the highest-priority request and form its mcause value
  always_comb begin
    take    = 1'b0;
    is_mret = 1'b0;
    is_irq  = 1'b0;
    cause   = {XLEN{1'b0}};
    if (exc_valid) begin
      take  = 1'b1;
      cause = {{(XLEN-4){1'b0}}, exc_code};
    end else if (mie && irq_ext) begin
      take   = 1'b1;
      is_irq = 1'b1;
      cause  = {1'b1, {(XLEN-5){1'b0}}, IRQ_EXT_CODE};
    end else if (mie && irq_timer) begin
      take   = 1'b1;
      is_irq = 1'b1;
      cause  = {1'b1, {(XLEN-5){1'b0}}, IRQ_TIMER_CODE};
    end else if (mret_req) begin
      take    = 1'b1;
      is_mret = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Accepts a trap or mret in IDLE,
// stalls until the pipeline drains, writes mepc/mcause/mstatus one per cycle
// through the CSR write port, then pulses a redirect+flush.
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt targets
// (mtvec mode 2'b01 -> base + 4*cause[3:0] for interrupts only).
// All outputs come from flops loaded with values decoded from the next state,
// so each output is valid for exactly the cycle its state is occupied.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            mret_req,
  input  logic [XLEN-1:0] next_pc,
  input  logic            pipe_drained,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            csr_w,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [1:0]      csr_wsc_mode,
  output logic            pipe_stall,
  output logic            pipe_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  import trap_pkg::*;

  // mstatus update on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus update on mret: MIE <- MPIE, MPIE <- 1, MPP <- M
  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            is_mret_q, is_mret_d;
  logic            is_irq_q, is_irq_d;

  logic            csr_w_q, csr_w_d;
  logic [11:0]     csr_waddr_q, csr_waddr_d;
  logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;
  logic [1:0]      csr_wsc_mode_q, csr_wsc_mode_d;
  logic            pipe_stall_q, pipe_stall_d;
  logic            pipe_flush_q, pipe_flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            busy_q, busy_d;

  logic            take_s;
  logic            pr_mret_s;
  logic            pr_irq_s;
  logic [XLEN-1:0] pr_cause_s;
  logic [XLEN-1:0] base_s;
  logic [XLEN-1:0] trap_target_s;
  logic [XLEN-1:0] status_next_s;
  logic            unused_epc_lo;

  trap_prio #(.XLEN(XLEN)) u_prio (
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .irq_ext   (irq_ext),
    .irq_timer (irq_timer),
    .mret_req  (mret_req),
    .mie       (mstatus[MSTATUS_MIE]),
    .take      (take_s),
    .is_mret   (pr_mret_s),
    .is_irq    (pr_irq_s),
    .cause     (pr_cause_s)
  );

  // mepc is always written word-aligned, so the low EPC bits never reach the port
  assign unused_epc_lo = ^epc_q[1:0];
  assign base_s        = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Trap handler address: vectored for interrupts when mtvec mode is 2'b01
  always_comb begin
    trap_target_s = base_s;
    if (is_irq_q && (mtvec[1:0] == 2'b01)) begin
      trap_target_s = base_s + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
    end else begin
      trap_target_s = base_s;
    end
  end
`else
  logic unused_vec_mode;
  assign unused_vec_mode = ^{mtvec[1:0], is_irq_q};

  // Trap handler address: always the mtvec base in the direct-only build
  always_comb begin
    trap_target_s = base_s;
  end
`endif

  // New mstatus value, taken from the live mstatus at the edge entering W_STATUS
  always_comb begin
    status_next_s = {XLEN{1'b0}};
    if (is_mret_q) begin
      status_next_s = mret_status(mstatus);
    end else begin
      status_next_s = trap_status(mstatus);
    end
  end

  // Next-state logic and request latching
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    is_mret_d = is_mret_q;
    is_irq_d  = is_irq_q;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d   = ST_DRAIN;
          cause_d   = pr_cause_s;
          is_mret_d = pr_mret_s;
          is_irq_d  = pr_irq_s;
          if (pr_irq_s) begin
            epc_d = next_pc;
          end else if (pr_mret_s) begin
            epc_d = {XLEN{1'b0}};
          end else begin
            epc_d = exc_pc;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pipe_drained) begin
          state_d = is_mret_q ? ST_W_STATUS : ST_W_EPC;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_W_EPC:    state_d = ST_W_CAUSE;
      ST_W_CAUSE:  state_d = ST_W_STATUS;
      ST_W_STATUS: state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so the output flops line up with the state flop
  always_comb begin
    csr_w_d          = 1'b0;
    csr_waddr_d      = 12'h000;
    csr_wdata_d      = {XLEN{1'b0}};
    csr_wsc_mode_d   = CSR_WMODE_WRITE;
    pipe_stall_d     = 1'b0;
    pipe_flush_d     = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = {XLEN{1'b0}};
    busy_d           = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_DRAIN: begin
        pipe_stall_d = 1'b1;
      end
      ST_W_EPC: begin
        pipe_stall_d = 1'b1;
        csr_w_d      = 1'b1;
        csr_waddr_d  = CSR_MEPC;
        csr_wdata_d  = {epc_q[XLEN-1:2], 2'b00};
      end
      ST_W_CAUSE: begin
        pipe_stall_d = 1'b1;
        csr_w_d      = 1'b1;
        csr_waddr_d  = CSR_MCAUSE;
        csr_wdata_d  = cause_q;
      end
      ST_W_STATUS: begin
        pipe_stall_d = 1'b1;
        csr_w_d      = 1'b1;
        csr_waddr_d  = CSR_MSTATUS;
        csr_wdata_d  = status_next_s;
      end
      ST_REDIRECT: begin
        pipe_stall_d     = 1'b1;
        pipe_flush_d     = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = is_mret_q ? mepc : trap_target_s;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, latched request and registered outputs; reset abandons any sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cause_q          <= {XLEN{1'b0}};
      epc_q            <= {XLEN{1'b0}};
      is_mret_q        <= 1'b0;
      is_irq_q         <= 1'b0;
      csr_w_q          <= 1'b0;
      csr_waddr_q      <= 12'h000;
      csr_wdata_q      <= {XLEN{1'b0}};
      csr_wsc_mode_q   <= 2'b00;
      pipe_stall_q     <= 1'b0;
      pipe_flush_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {XLEN{1'b0}};
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      is_mret_q        <= is_mret_d;
      is_irq_q         <= is_irq_d;
      csr_w_q          <= csr_w_d;
      csr_waddr_q      <= csr_waddr_d;
      csr_wdata_q      <= csr_wdata_d;
      csr_wsc_mode_q   <= csr_wsc_mode_d;
      pipe_stall_q     <= pipe_stall_d;
      pipe_flush_q     <= pipe_flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign csr_w          = csr_w_q;
  assign csr_waddr      = csr_waddr_q;
  assign csr_wdata      = csr_wdata_q;
  assign csr_wsc_mode   = csr_wsc_mode_q;
  assign pipe_stall     = pipe_stall_q;
  assign pipe_flush     = pipe_flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic        irq_ext;
  logic        irq_timer;
  logic        mret_req;
  logic [31:0] next_pc;
  logic        pipe_drained;
  logic [31:0] mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        csr_w;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_wsc_mode;
  logic        pipe_stall;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .mret_req       (mret_req),
    .next_pc        (next_pc),
    .pipe_drained   (pipe_drained),
    .mstatus        (mstatus),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .csr_w          (csr_w),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_wsc_mode   (csr_wsc_mode),
    .pipe_stall     (pipe_stall),
    .pipe_flush     (pipe_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Checks one cycle of CSR port state
  task automatic chk_csr(input string tag, input logic w, input logic [11:0] a, input logic [31:0] d);
    chk({tag, ".csr_w"}, {31'd0, csr_w}, {31'd0, w});
    chk({tag, ".waddr"}, {20'd0, csr_waddr}, {20'd0, a});
    chk({tag, ".wdata"}, csr_wdata, d);
  endtask

  // Checks the control/redirect outputs
  task automatic chk_ctl(input string tag, input logic bsy, input logic stl, input logic rv, input logic [31:0] pc);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
    chk({tag, ".stall"}, {31'd0, pipe_stall}, {31'd0, stl});
    chk({tag, ".redir"}, {31'd0, redirect_valid}, {31'd0, rv});
    chk({tag, ".flush"}, {31'd0, pipe_flush}, {31'd0, rv});
    chk({tag, ".rpc"}, redirect_pc, pc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {31'd0, |{csr_w, csr_waddr, csr_wdata, csr_wsc_mode, pipe_stall,
                                  pipe_flush, redirect_valid, redirect_pc, busy}}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 32'd0;
    irq_ext = 1'b0; irq_timer = 1'b0; mret_req = 1'b0; next_pc = 32'h0000_0900;
    pipe_drained = 1'b1; mstatus = 32'd0; mtvec = 32'h0000_0200; mepc = 32'd0;

    // Reset state
    step();
    chk_all_zero("rst");
    step();
    rst_n = 1'b1;
    step();
    chk_ctl("idle0", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("wmode", {30'd0, csr_wsc_mode}, 32'd1);

    // Exception, code 2, drained already
    mstatus = 32'h8; exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h100;
    step();
    chk_ctl("e1.c1", 1'b1, 1'b1, 1'b0, 32'd0);
    chk_csr("e1.c1", 1'b0, 12'h000, 32'd0);
    exc_valid = 1'b0;
    step(); chk_csr("e1.c2", 1'b1, 12'h341, 32'h100);
    step(); chk_csr("e1.c3", 1'b1, 12'h342, 32'h2);
    step(); chk_csr("e1.c4", 1'b1, 12'h300, 32'h1880);
    step();
    chk_csr("e1.c5", 1'b0, 12'h000, 32'd0);
    chk_ctl("e1.c5", 1'b1, 1'b1, 1'b1, 32'h200);
    mstatus = 32'h1880;
    step(); chk_ctl("e1.c6", 1'b0, 1'b0, 1'b0, 32'd0);

    // Timer interrupt masked by MIE=0
    mstatus = 32'h0; irq_timer = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("tmr.busy", {31'd0, busy}, 32'd0);
    end
    irq_timer = 1'b0;

    // Exception and external interrupt together: exception wins
    mstatus = 32'h8; irq_ext = 1'b1; exc_valid = 1'b1; exc_code = 4'd11; exc_pc = 32'h300;
    step(); chk("both.busy", {31'd0, busy}, 32'd1);
    exc_valid = 1'b0;
    step(); chk_csr("both.epc", 1'b1, 12'h341, 32'h300);
    step(); chk_csr("both.cause", 1'b1, 12'h342, 32'h0000_000B);
    step(); chk_csr("both.st", 1'b1, 12'h300, 32'h1880);
    step(); chk_ctl("both.redir", 1'b1, 1'b1, 1'b1, 32'h200);
    mstatus = 32'h1880;
    step(); chk("both.idle", {31'd0, busy}, 32'd0);
    step(); chk("both.norefire", {31'd0, busy}, 32'd0);
    irq_ext = 1'b0;

    // mret
    mstatus = 32'h1880; mepc = 32'h104; mret_req = 1'b1;
    step();
    chk_ctl("mret.c1", 1'b1, 1'b1, 1'b0, 32'd0);
    chk("mret.c1.w", {31'd0, csr_w}, 32'd0);
    mret_req = 1'b0;
    step(); chk_csr("mret.c2", 1'b1, 12'h300, 32'h1888);
    step(); chk_ctl("mret.c3", 1'b1, 1'b1, 1'b1, 32'h104);
    chk("mret.c3.w", {31'd0, csr_w}, 32'd0);
    mstatus = 32'h1888;
    step(); chk_ctl("mret.c4", 1'b0, 1'b0, 1'b0, 32'd0);

    // Drain held off for 5 cycles
    mstatus = 32'h0; pipe_drained = 1'b0; exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h403;
    step();
    exc_valid = 1'b0;
    chk("drn.stall", {31'd0, pipe_stall}, 32'd1);
    chk("drn.w", {31'd0, csr_w}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drn.stall", {31'd0, pipe_stall}, 32'd1);
      chk("drn.w", {31'd0, csr_w}, 32'd0);
    end
    pipe_drained = 1'b1;
    step(); chk_csr("drn.epc", 1'b1, 12'h341, 32'h400);
    step(); chk_csr("drn.cause", 1'b1, 12'h342, 32'h5);
    step(); chk_csr("drn.st", 1'b1, 12'h300, 32'h1800);
    step(); chk_ctl("drn.redir", 1'b1, 1'b1, 1'b1, 32'h200);
    step(); chk("drn.idle", {31'd0, busy}, 32'd0);

    // External interrupt with mtvec mode 01
    mstatus = 32'h8; mtvec = 32'h201; next_pc = 32'h500; irq_ext = 1'b1;
    step();
    irq_ext = 1'b0;
    chk("irq.busy", {31'd0, busy}, 32'd1);
    step(); chk_csr("irq.epc", 1'b1, 12'h341, 32'h500);
    step(); chk_csr("irq.cause", 1'b1, 12'h342, 32'h8000_000B);
    step(); chk_csr("irq.st", 1'b1, 12'h300, 32'h1880);
    step();
`ifdef TRAP_VECTORED_EN
    chk_ctl("irq.redir", 1'b1, 1'b1, 1'b1, 32'h22C);
`else
    chk_ctl("irq.redir", 1'b1, 1'b1, 1'b1, 32'h200);
`endif
    mstatus = 32'h1880; mtvec = 32'h200;
    step(); chk("irq.idle", {31'd0, busy}, 32'd0);

    // Reset pulsed during W_CAUSE
    mstatus = 32'h8; exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'h600;
    step(); exc_valid = 1'b0;
    step(); chk_csr("rmid.epc", 1'b1, 12'h341, 32'h600);
    step(); chk_csr("rmid.cause", 1'b1, 12'h342, 32'h3);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rmid.async");
    step();
    chk_all_zero("rmid.held");
    rst_n = 1'b1;
    mstatus = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ctl("rmid.after", 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rmid.after.w", {31'd0, csr_w}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
